// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter.
// Helpers work on a fixed 16-bit span so they cover every legal requester count.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int PICK_SPAN = 16;

  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < PICK_SPAN; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

  // Rotate the low n bits of vec right by sh (sh < n), clearing everything above n.
  function automatic logic [15:0] rot_mask(input logic [15:0] vec, input logic [4:0] sh,
                                           input logic [4:0] n);
    logic [31:0] dbl;
    logic [31:0] mask;
    dbl  = {16'b0, vec} | ({16'b0, vec} << n);
    mask = (32'd1 << n) - 32'd1;
    return 16'((dbl >> sh) & mask);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after last_ptr, wrapping.
// Uses a double-width rotate, lowest-set-bit isolate, then index un-rotate.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [15:0] req_w;
  logic [15:0] rot;
  logic [15:0] iso;
  logic [4:0]  start;
  logic [3:0]  off;
  logic [4:0]  sum;

  always_comb begin
    req_w = '0;
    req_w[N_REQ-1:0] = req;
    start = 5'(last_ptr) + 5'd1;
    if (start >= 5'(N_REQ)) start = 5'd0;
    rot = rot_mask(req_w, start, 5'(N_REQ));
    iso = rot & (~rot + 16'd1);
    off = onehot_to_idx(iso);
    sum = 5'(off) + start;
    if (sum >= 5'(N_REQ)) sum = sum - 5'(N_REQ);
    found = |req;
    idx   = ID_W'(sum);
  end

endmodule

// File: rtl/rr_burst_lock_arb.sv
// Round-robin arbiter that locks the grant for a whole burst, releasing on the
// last beat, on the beat cap (with a preempt pulse), or when the owner drops req.
//
// state | meaning
// IDLE  | no grant held; arbitrate req, grant registers on next edge
// GRANT | gnt locked to gnt_id; count beats until last/cap/abandon
module rr_burst_lock_arb
  import arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 8,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_last,
  input  logic             rsrc_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             beat,
  output logic             preempt
);

  arb_state_e       state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]  gnt_id_nxt;
  logic             busy_nxt;
  logic             preempt_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic [ID_W-1:0]  last_ptr, last_ptr_nxt;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             cur_req;
  logic             cur_last;
  logic             cap_hit;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign cur_req  = req[gnt_id];
  assign cur_last = req_last[gnt_id];
  assign beat     = busy & cur_req & rsrc_ready;
  assign cnt_inc  = {1'b0, beat_cnt} + (CNT_W+1)'(1);
  assign cap_hit  = (cnt_inc == (CNT_W+1)'(MAX_BEATS));

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    busy_nxt     = busy;
    preempt_nxt  = 1'b0;
    cnt_nxt      = beat_cnt;
    last_ptr_nxt = last_ptr;
    unique case (state)
      IDLE: begin
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
        busy_nxt   = 1'b0;
        if (pick_found) begin
          gnt_nxt      = N_REQ'(1) << pick_idx;
          gnt_id_nxt   = pick_idx;
          last_ptr_nxt = pick_idx;
          cnt_nxt      = '0;
          busy_nxt     = 1'b1;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (!cur_req || (beat && (cur_last || cap_hit))) begin
          // A last beat that also hits the cap is a normal release.
          preempt_nxt = cur_req && beat && !cur_last && cap_hit;
          gnt_nxt     = '0;
          gnt_id_nxt  = '0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else if (beat) begin
          cnt_nxt = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      beat_cnt <= '0;
      last_ptr <= ID_W'(N_REQ - 1);
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      preempt  <= preempt_nxt;
      beat_cnt <= cnt_nxt;
      last_ptr <= last_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_burst_lock_arb.sv
// Directed bench for rr_burst_lock_arb with N_REQ=4, MAX_BEATS=4.
module tb_rr_burst_lock_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] req_last = '0;
  logic       rsrc_ready = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       beat;
  logic       preempt;

  int total = 0;
  int bad = 0;

  rr_burst_lock_arb #(.N_REQ(4), .MAX_BEATS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_last   (req_last),
    .rsrc_ready (rsrc_ready),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .beat       (beat),
    .preempt    (preempt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    total++;
    if ((gnt & (gnt - 4'd1)) !== 4'd0) begin
      bad++;
      $display("FAIL onehot gnt=%b required one-hot or zero", gnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_last = '0; rsrc_ready = 1'b0;
    tick(); tick();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0 || preempt !== 1'b0 || beat !== 1'b0) begin
      bad++;
      $display("FAIL reset gnt=%b busy=%b id=%0d pre=%b beat=%b required 0000 0 0 0 0",
               gnt, busy, gnt_id, preempt, beat);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    logic [1:0] exp_id [5];
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b1; req = 4'hF; rsrc_ready = 1'b1; req_last = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (gnt !== exp_g[k] || gnt_id !== exp_id[k] || busy !== 1'b1 || preempt !== 1'b0) begin
        bad++;
        $display("FAIL rot_grant%0d gnt=%b id=%0d busy=%b pre=%b required %b %0d 1 0",
                 k, gnt, gnt_id, busy, preempt, exp_g[k], exp_id[k]);
      end
      #1;
      total++;
      if (beat !== 1'b1) begin bad++; $display("FAIL rot_beat1_%0d beat=%b required 1", k, beat); end
      tick();
      req_last = 4'hF;
      #1;
      total++;
      if (gnt !== exp_g[k] || beat !== 1'b1) begin
        bad++;
        $display("FAIL rot_beat2_%0d gnt=%b beat=%b required %b 1", k, gnt, beat, exp_g[k]);
      end
      tick();
      req_last = '0;
      if (k == 4) req = '0;
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0) begin
        bad++;
        $display("FAIL rot_dead%0d gnt=%b busy=%b pre=%b required 0000 0 0", k, gnt, busy, preempt);
      end
      #1;
      total++;
      if (beat !== 1'b0) begin bad++; $display("FAIL rot_dead_beat%0d beat=%b required 0", k, beat); end
    end
  endtask

  task automatic test_cap();
    tick();
    req = 4'b0100; rsrc_ready = 1'b1; req_last = '0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        total++;
        if (gnt !== 4'b0100 || preempt !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL cap_hold b%0d i%0d gnt=%b pre=%b busy=%b required 0100 0 1",
                   b, i, gnt, preempt, busy);
        end
        #1;
        total++;
        if (beat !== 1'b1) begin bad++; $display("FAIL cap_beat b%0d i%0d beat=%b required 1", b, i, beat); end
      end
      tick();
      if (b == 1) req = '0;
      total++;
      if (gnt !== 4'b0000 || preempt !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL cap_release b%0d gnt=%b pre=%b busy=%b required 0000 1 0", b, gnt, preempt, busy);
      end
    end
  endtask

  task automatic test_stall();
    logic rdy [5];
    int   beats;
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    beats = 0;
    tick();
    req = 4'b0010; req_last = '0; rsrc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
        bad++;
        $display("FAIL stall_hold i%0d gnt=%b id=%0d required 0010 1", i, gnt, gnt_id);
      end
      rsrc_ready = rdy[i];
      req_last = (i == 4) ? 4'b0010 : 4'b0000;
      #1;
      total++;
      if (beat !== rdy[i]) begin bad++; $display("FAIL stall_beat i%0d beat=%b required %b", i, beat, rdy[i]); end
      if (beat === 1'b1) beats++;
    end
    tick();
    req = '0; req_last = '0; rsrc_ready = 1'b1;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0) begin
      bad++;
      $display("FAIL stall_release gnt=%b busy=%b pre=%b required 0000 0 0", gnt, busy, preempt);
    end
    total++;
    if (beats !== 3) begin bad++; $display("FAIL stall_count beats=%0d required 3", beats); end
  endtask

  task automatic test_abandon();
    tick();
    req = 4'b1001; req_last = '0; rsrc_ready = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      bad++;
      $display("FAIL abandon_grant gnt=%b id=%0d required 1000 3", gnt, gnt_id);
    end
    #1;
    total++;
    if (beat !== 1'b1) begin bad++; $display("FAIL abandon_beat1 beat=%b required 1", beat); end
    tick();
    req = 4'b0001;
    #1;
    total++;
    if (gnt !== 4'b1000 || beat !== 1'b0) begin
      bad++;
      $display("FAIL abandon_drop gnt=%b beat=%b required 1000 0", gnt, beat);
    end
    tick();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0 || beat !== 1'b0) begin
      bad++;
      $display("FAIL abandon_dead gnt=%b busy=%b pre=%b beat=%b required 0000 0 0 0",
               gnt, busy, preempt, beat);
    end
    tick();
    req = '0;
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL abandon_next gnt=%b id=%0d required 0001 0", gnt, gnt_id);
    end
    tick();
  endtask

  task automatic test_coincide();
    tick();
    req = 4'b0100; req_last = '0; rsrc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (gnt !== 4'b0100 || preempt !== 1'b0) begin
        bad++;
        $display("FAIL coin_hold i%0d gnt=%b pre=%b required 0100 0", i, gnt, preempt);
      end
      if (i == 3) req_last = 4'b0100;
      #1;
      total++;
      if (beat !== 1'b1) begin bad++; $display("FAIL coin_beat i%0d beat=%b required 1", i, beat); end
    end
    tick();
    req = '0; req_last = '0;
    total++;
    if (gnt !== 4'b0000 || preempt !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL coin_release gnt=%b pre=%b busy=%b required 0000 0 0", gnt, preempt, busy);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req = 4'b0010; req_last = '0; rsrc_ready = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL rmid_grant gnt=%b required 0010", gnt); end
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0 || beat !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async gnt=%b busy=%b id=%0d beat=%b required 0000 0 0 0",
               gnt, busy, gnt_id, beat);
    end
    req = 4'hF;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL rmid_first gnt=%b id=%0d required 0001 0", gnt, gnt_id);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_cap();
    test_stall();
    test_abandon();
    test_coincide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
